updown_mod_counter: RTL and testbench

//  Parametrised up/down modulo counter, successor to the fixed 4-bit enable counter.

---
 rtl/counter_pkg.sv | 47 ++++
 rtl/counter_tc_logic.sv | 34 +++
 rtl/updown_mod_counter.sv | 152 +++++++++++++++
 tb/tb_updown_mod_counter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the up/down modulo counter family.
// Purpose: mode constants and the next-count helper. Latency: n/a (package).
// Backpressure: n/a; contents: CNT_WRAP/CNT_SAT, cnt_arith_t, cnt_step_t, f_next_count().
package counter_pkg;

  // Range-end behaviour: wrap to the opposite end, or hold at the end reached.
  localparam logic CNT_WRAP = 1'b0;
  localparam logic CNT_SAT  = 1'b1;

  // Widest count register supported. The arithmetic carries one extra bit so that
  // MODULUS = 2**WIDTH is representable and +1/-1 never aliases into range.
  localparam int CNT_MAX_WIDTH = 32;
  localparam int CNT_AW        = CNT_MAX_WIDTH + 1;

  typedef logic [CNT_AW-1:0] cnt_arith_t;

  // {event, next}: event = the step lands on a range end (wrap or saturation).
  typedef struct packed {
    logic       evt;
    cnt_arith_t nxt;
  } cnt_step_t;

  localparam cnt_arith_t CNT_ONE = cnt_arith_t'(1);

  // Next value of a counter that is stepping. count must already be in
  // 0..modulus-1; the result stays in that range in both modes.
  function automatic cnt_step_t f_next_count(
    input cnt_arith_t count,
    input logic       up,
    input cnt_arith_t modulus,
    input logic       sat
  );
    cnt_step_t  res;
    cnt_arith_t top_val;
    top_val = modulus - CNT_ONE;
    res.evt = up ? (count == top_val) : (count == '0);
    if (!res.evt) begin
      res.nxt = up ? (count + CNT_ONE) : (count - CNT_ONE);
    end else if (sat == CNT_SAT) begin
      res.nxt = count;
    end else begin
      res.nxt = up ? '0 : top_val;
    end
    return res;
  endfunction

endpackage

// File: rtl/counter_tc_logic.sv
// Terminal-count and range-end detection for updown_mod_counter.
// Latency: purely combinational, zero cycles. Backpressure: none.
// Ports: count_i (current count), en_i/cin_i/up_i (step controls),
//        range_end_o (count sits at the end the current direction heads to),
//        tc_o (carry-out: range end AND this stage is enabled to step).
module counter_tc_logic
  import counter_pkg::*;
#(
  parameter int     WIDTH   = 4,
  parameter longint MODULUS = 16
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic             en_i,
  input  logic             cin_i,
  input  logic             up_i,
  output logic             range_end_o,
  output logic             tc_o
);

  localparam cnt_arith_t       MAX_A   = cnt_arith_t'(MODULUS - 1);
  localparam logic [WIDTH-1:0] MAX_CNT = MAX_A[WIDTH-1:0];

  logic at_max;
  logic at_min;

  assign at_max      = (count_i == MAX_CNT);
  assign at_min      = (count_i == '0);
  assign range_end_o = up_i ? at_max : at_min;

  // Carry-out is gated by this stage's own enable and carry-in so that a chain
  // ripples combinationally and every stage steps on the same edge.
  assign tc_o = en_i & cin_i & range_end_o;

endmodule

// File: rtl/updown_mod_counter.sv
// Parametrised up/down modulo counter with wrap/saturate, sync clear/load, cascade carry.
// Latency: count/wrapped/ovf registered (update on the selected edge); tc is combinational.
// Backpressure: none; cin gates stepping so cascaded stages advance together.
// Ports: clk, rst (async, active-high), clr, load, din[WIDTH], en, cin, up ->
//        count[WIDTH], tc (carry-out), wrapped (one-edge range-end pulse), ovf (sticky).
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int     WIDTH    = 4,
  parameter longint MODULUS  = 16,
  parameter int     NEG_EDGE = 1,
  parameter int     SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  input  logic             cin,
  input  logic             up,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrapped,
  output logic             ovf
);

  // ---------------------------------------------------------------------------
  // Parameter sanity
  // ---------------------------------------------------------------------------
  if (WIDTH < 1 || WIDTH > CNT_MAX_WIDTH) begin : g_bad_width
    $error("updown_mod_counter: WIDTH must be 1..32");
  end
  if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_modulus
    $error("updown_mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end

  localparam cnt_arith_t       MOD_A    = cnt_arith_t'(MODULUS);
  localparam logic [WIDTH:0]   MOD_W    = MOD_A[WIDTH:0];
  localparam cnt_arith_t       MAX_A    = cnt_arith_t'(MODULUS - 1);
  localparam logic [WIDTH-1:0] MAX_CNT  = MAX_A[WIDTH-1:0];
  localparam logic             SAT_MODE = (SATURATE != 0) ? CNT_SAT : CNT_WRAP;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             wrapped_q;
  logic             wrapped_d;
  logic             ovf_q;
  logic             ovf_d;

  logic             step;
  logic             range_end;
  logic [WIDTH-1:0] load_val;
  cnt_arith_t       cnt_ext;
  cnt_step_t        step_res;
  logic             unused_nxt_hi;

  // ---------------------------------------------------------------------------
  // Terminal count / range-end detect, shared by tc and the step flags
  // ---------------------------------------------------------------------------
  counter_tc_logic #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_tc (
    .count_i     (count_q),
    .en_i        (en),
    .cin_i       (cin),
    .up_i        (up),
    .range_end_o (range_end),
    .tc_o        (tc)
  );

  // ---------------------------------------------------------------------------
  // Next-state arithmetic
  // ---------------------------------------------------------------------------
  assign step    = en & cin;
  assign cnt_ext = {{(CNT_AW-WIDTH){1'b0}}, count_q};

  always_comb begin
    step_res = f_next_count(cnt_ext, up, MOD_A, SAT_MODE);
  end

  // The helper always returns a value below MODULUS, so the bits above WIDTH
  // are zero by construction and only the low WIDTH bits are registered.
  assign unused_nxt_hi = ^step_res.nxt[CNT_AW-1:WIDTH];

  // Load values outside the range are clamped to the top of the range.
  // Compared in WIDTH+1 bits so MODULUS = 2**WIDTH needs no special case.
  assign load_val = ({1'b0, din} >= MOD_W) ? MAX_CNT : din;

  // clr > load > step; wrapped is a pulse, so it defaults low on every edge.
  always_comb begin
    count_d   = count_q;
    wrapped_d = 1'b0;
    ovf_d     = ovf_q;
    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (load) begin
      count_d = load_val;
    end else if (step) begin
      count_d = step_res.nxt[WIDTH-1:0];
      if (range_end) begin
        wrapped_d = 1'b1;
        ovf_d     = 1'b1;
      end
    end
  end

  // The helper and the detect sub-module decide "range end" independently;
  // they must always agree.
  always_comb begin
    assert (step_res.evt == range_end);
  end

  // ---------------------------------------------------------------------------
  // State register: edge chosen at elaboration, clock used un-inverted
  // ---------------------------------------------------------------------------
  if (NEG_EDGE != 0) begin : g_neg_edge
    always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
        count_q   <= '0;
        wrapped_q <= 1'b0;
        ovf_q     <= 1'b0;
      end else begin
        count_q   <= count_d;
        wrapped_q <= wrapped_d;
        ovf_q     <= ovf_d;
      end
    end
  end else begin : g_pos_edge
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        count_q   <= '0;
        wrapped_q <= 1'b0;
        ovf_q     <= 1'b0;
      end else begin
        count_q   <= count_d;
        wrapped_q <= wrapped_d;
        ovf_q     <= ovf_d;
      end
    end
  end

  assign count   = count_q;
  assign wrapped = wrapped_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: five instances (wrap, saturate, two cascaded, posedge).
// Stimulus pushes expected {count, tc, wrapped, ovf} into a queue; a monitor
// drains the queue 3 time units after every clock edge and compares.
module tb_updown_mod_counter;

  localparam int N = 5;  // 0: wrap, 1: saturate, 2/3: cascade lo/hi, 4: posedge

  logic       clk = 1'b1;
  logic       rst;
  logic       clr_r  [N];
  logic       load_r [N];
  logic [3:0] din_r  [N];
  logic       en_r   [N];
  logic       cin_r  [N];
  logic       up_r   [N];
  logic [3:0] count_w[N];
  logic       tc_w   [N];
  logic       wr_w   [N];
  logic       ovf_w  [N];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         idx;
    logic [3:0] cnt;
    logic       tc;
    logic       wr;
    logic       ovf;
    string      tag;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .NEG_EDGE(1), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .clr(clr_r[0]), .load(load_r[0]), .din(din_r[0]),
    .en(en_r[0]), .cin(cin_r[0]), .up(up_r[0]),
    .count(count_w[0]), .tc(tc_w[0]), .wrapped(wr_w[0]), .ovf(ovf_w[0]));

  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .NEG_EDGE(1), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .clr(clr_r[1]), .load(load_r[1]), .din(din_r[1]),
    .en(en_r[1]), .cin(cin_r[1]), .up(up_r[1]),
    .count(count_w[1]), .tc(tc_w[1]), .wrapped(wr_w[1]), .ovf(ovf_w[1]));

  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .NEG_EDGE(1), .SATURATE(0)) u_casc_lo (
    .clk(clk), .rst(rst), .clr(clr_r[2]), .load(load_r[2]), .din(din_r[2]),
    .en(en_r[2]), .cin(cin_r[2]), .up(up_r[2]),
    .count(count_w[2]), .tc(tc_w[2]), .wrapped(wr_w[2]), .ovf(ovf_w[2]));

  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .NEG_EDGE(1), .SATURATE(0)) u_casc_hi (
    .clk(clk), .rst(rst), .clr(clr_r[3]), .load(load_r[3]), .din(din_r[3]),
    .en(en_r[3]), .cin(tc_w[2]), .up(up_r[3]),
    .count(count_w[3]), .tc(tc_w[3]), .wrapped(wr_w[3]), .ovf(ovf_w[3]));

  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .NEG_EDGE(0), .SATURATE(0)) u_pos (
    .clk(clk), .rst(rst), .clr(clr_r[4]), .load(load_r[4]), .din(din_r[4]),
    .en(en_r[4]), .cin(cin_r[4]), .up(up_r[4]),
    .count(count_w[4]), .tc(tc_w[4]), .wrapped(wr_w[4]), .ovf(ovf_w[4]));

  task automatic set_in(input int i, input int c, input int l, input int d,
                        input int e, input int ci, input int u);
    clr_r[i]  = (c != 0);
    load_r[i] = (l != 0);
    din_r[i]  = 4'(d);
    en_r[i]   = (e != 0);
    cin_r[i]  = (ci != 0);
    up_r[i]   = (u != 0);
  endtask

  task automatic push(input int i, input int c, input int t, input int w,
                      input int o, input string tag);
    exp_t x;
    x.idx = i;
    x.cnt = 4'(c);
    x.tc  = (t != 0);
    x.wr  = (w != 0);
    x.ovf = (o != 0);
    x.tag = tag;
    exp_q.push_back(x);
  endtask

  // Negedge instances: drive after posedge, expect after the following negedge.
  task automatic nstep(input int i, input int c, input int l, input int d,
                       input int e, input int ci, input int u,
                       input int ec, input int et, input int ew, input int eo,
                       input string tag);
    @(posedge clk); #1;
    set_in(i, c, l, d, e, ci, u);
    @(negedge clk); #2;
    push(i, ec, et, ew, eo, tag);
  endtask

  // Posedge instance: drive after negedge, expect after the following posedge.
  task automatic pstep(input int c, input int l, input int d,
                       input int e, input int ci, input int u,
                       input int ec, input int et, input int ew, input int eo,
                       input string tag);
    @(negedge clk); #4;
    set_in(4, c, l, d, e, ci, u);
    @(posedge clk); #2;
    push(4, ec, et, ew, eo, tag);
  endtask

  // Monitor: compares every pending expectation shortly after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or negedge clk);
      #3;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (count_w[e.idx] !== e.cnt || tc_w[e.idx] !== e.tc ||
            wr_w[e.idx] !== e.wr || ovf_w[e.idx] !== e.ovf) begin
          errors++;
          $display("FAIL %s dut%0d @%0t: got count=%0d tc=%b wrapped=%b ovf=%b, want count=%0d tc=%b wrapped=%b ovf=%b",
                   e.tag, e.idx, $time, count_w[e.idx], tc_w[e.idx], wr_w[e.idx], ovf_w[e.idx],
                   e.cnt, e.tc, e.wr, e.ovf);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) set_in(i, 0, 0, 0, 0, 1, 1);
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < N; i++) push(i, 0, 0, 0, 0, "reset");
    #10 rst = 1'b0;

    // Down from 0 wraps to 9 and sets ovf, then counts down to 7.
    nstep(0, 0, 0, 0, 1, 1, 0, 9, 0, 1, 1, "down_wrap");
    nstep(0, 0, 0, 0, 1, 1, 0, 8, 0, 0, 1, "down_8");
    nstep(0, 0, 0, 0, 1, 1, 0, 7, 0, 0, 1, "down_7");
    // A posedge with en=1 must not move a negedge counter.
    @(posedge clk); #1 up_r[0] = 1'b1;
    #1 push(0, 7, 0, 0, 1, "posedge_hold");
    @(negedge clk); #2 push(0, 8, 0, 0, 1, "up_8");
    // Async reset mid-cycle clears before the next negedge.
    @(posedge clk); #1 rst = 1'b1;
    #1 push(0, 0, 0, 0, 0, "async_rst");
    @(negedge clk); #2 push(0, 0, 0, 0, 0, "rst_held");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); #2 push(0, 1, 0, 0, 0, "post_rst");

    // Full up run from 0: 1..9 then wrap to 0.
    nstep(0, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0, "clr");
    for (int k = 1; k <= 10; k++)
      nstep(0, 0, 0, 0, 1, 1, 1, k % 10, int'((k % 10) == 9), int'(k == 10), int'(k == 10), "up_run");

    // Load clamping and priorities.
    nstep(0, 0, 1, 13, 0, 1, 1, 9, 0, 0, 1, "load_clamp13");
    nstep(0, 0, 1, 5,  0, 1, 1, 5, 0, 0, 1, "load_5");
    nstep(0, 0, 1, 10, 0, 1, 1, 9, 0, 0, 1, "load_clamp10");
    nstep(0, 1, 1, 3,  1, 1, 1, 0, 0, 0, 0, "clr_over_load");
    nstep(0, 0, 1, 9,  1, 1, 1, 9, 1, 0, 0, "load_over_step");
    nstep(0, 0, 0, 0,  1, 0, 1, 9, 0, 0, 0, "cin_hold");
    nstep(0, 0, 0, 0,  1, 1, 0, 8, 0, 0, 0, "dir_change");

    // Saturating instance.
    nstep(1, 0, 1, 1, 0, 1, 0, 1, 0, 0, 0, "sat_load1");
    nstep(1, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, "sat_dn1");
    nstep(1, 0, 0, 0, 1, 1, 0, 0, 1, 1, 1, "sat_dn2");
    nstep(1, 0, 0, 0, 1, 1, 0, 0, 1, 1, 1, "sat_dn3");
    nstep(1, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, "sat_up");
    nstep(1, 0, 1, 9, 0, 1, 1, 9, 0, 0, 1, "sat_load9");
    nstep(1, 0, 0, 0, 1, 1, 1, 9, 1, 1, 1, "sat_top");

    // Two-digit decimal cascade: 00 -> 99 -> 00.
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      set_in(2, 0, 0, 0, 1, 1, 1);
      set_in(3, 0, 0, 0, 1, 1, 1);
      @(negedge clk); #2;
      push(2, k % 10, int'((k % 10) == 9), int'((k % 10) == 0), int'(k >= 10), "casc_lo");
      push(3, (k / 10) % 10, int'(((k % 10) == 9) && (((k / 10) % 10) == 9)),
           int'(k == 100), int'(k == 100), "casc_hi");
    end

    // Posedge instance.
    pstep(0, 0, 0, 1, 1, 1, 1, 0, 0, 0, "pos_1");
    pstep(0, 0, 0, 1, 1, 1, 2, 0, 0, 0, "pos_2");
    pstep(0, 0, 0, 0, 1, 1, 2, 0, 0, 0, "pos_en0");
    pstep(0, 0, 0, 1, 0, 1, 2, 0, 0, 0, "pos_cin0");
    pstep(0, 1, 9, 0, 1, 1, 9, 0, 0, 0, "pos_load9");
    pstep(0, 0, 0, 1, 0, 1, 9, 0, 0, 0, "pos_tc_cin0");
    pstep(0, 0, 0, 1, 1, 1, 0, 0, 1, 1, "pos_wrap");
    @(negedge clk); #2 push(4, 0, 0, 1, 1, "pos_negedge_hold");

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations pending, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
